// File: rtl/bramfeeder_put_arbiter.sv
// Packet-atomic round-robin arbiter sharing the bramfeeder ppcMessageInput put channel.
// A grant is held from the header beat through the last payload word; mid-packet starvation raises a sticky error.
module bramfeeder_put_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int LEN_BITS    = 8,
  parameter int STALL_LIMIT = 1024
) (
  input  logic                    sys_clk_pin,
  input  logic                    sys_rst_pin,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [32*NUM_REQ-1:0]   req_data,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic                    RDY_ppcMessageInput_put,
  output logic                    EN_ppcMessageInput_put,
  output logic [31:0]             ppcMessageInput_put,
  output logic                    busy,
  output logic [2:0]              grant_id,
  output logic                    stall_err,
  input  logic                    clr_err
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int CW = $clog2(STALL_LIMIT + 1);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t              r_state, w_state_nxt;
  logic [GW-1:0]       r_rr_ptr, r_grant, w_pick;
  logic [LEN_BITS-1:0] r_remaining;
  logic                r_hdr_pending;
  logic [CW-1:0]       r_stall_cnt;
  logic                r_stall_err;

  logic                w_busy, w_gvalid, w_en, w_found, w_pkt_end, w_stall_set;
  logic [31:0]         w_word;

  assign w_busy   = (r_state == S_BUSY);
  assign w_gvalid = req_valid[r_grant];
  assign w_en     = w_busy & w_gvalid & RDY_ppcMessageInput_put;
  assign w_word   = w_busy ? req_data[32*int'(r_grant) +: 32] : 32'd0;

  // First valid source strictly after the last winner, wrapping.
  always_comb begin
    int idx;
    idx     = 0;
    w_found = 1'b0;
    w_pick  = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx = (int'(r_rr_ptr) + i) % NUM_REQ;
      if (!w_found && req_valid[idx]) begin
        w_found = 1'b1;
        w_pick  = GW'(idx);
      end
    end
  end

  always_comb begin
    w_pkt_end   = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_found) w_state_nxt = S_BUSY;
      S_BUSY: begin
        if (w_en)
          w_pkt_end = r_hdr_pending ? (w_word[LEN_BITS-1:0] == '0)
                                    : (r_remaining == LEN_BITS'(1));
        if (w_pkt_end) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_stall_set = w_busy & ~w_gvalid & (r_stall_cnt == CW'(STALL_LIMIT - 1));

  always_ff @(posedge sys_clk_pin or negedge sys_rst_pin) begin
    if (!sys_rst_pin) begin
      r_state       <= S_IDLE;
      r_rr_ptr      <= GW'(NUM_REQ - 1);
      r_grant       <= '0;
      r_remaining   <= '0;
      r_hdr_pending <= 1'b0;
      r_stall_cnt   <= '0;
      r_stall_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == S_IDLE) begin
        r_stall_cnt <= '0;
        if (w_found) begin
          r_grant       <= w_pick;
          r_hdr_pending <= 1'b1;
        end
      end else begin
        if (w_en) begin
          r_stall_cnt <= '0;
          if (r_hdr_pending) begin
            r_remaining   <= w_word[LEN_BITS-1:0];
            r_hdr_pending <= 1'b0;
          end else begin
            r_remaining <= r_remaining - LEN_BITS'(1);
          end
        end else if (!w_gvalid && r_stall_cnt != CW'(STALL_LIMIT)) begin
          r_stall_cnt <= r_stall_cnt + CW'(1);
        end
        if (w_pkt_end) r_rr_ptr <= r_grant;
      end
      // Set has priority over clear.
      if (w_stall_set)  r_stall_err <= 1'b1;
      else if (clr_err) r_stall_err <= 1'b0;
    end
  end

  always_comb begin
    req_ready = '0;
    if (w_busy) req_ready[r_grant] = RDY_ppcMessageInput_put;
  end

  assign EN_ppcMessageInput_put = w_en;
  assign ppcMessageInput_put    = w_word;
  assign busy                   = w_busy;
  assign grant_id               = 3'(r_grant);
  assign stall_err              = r_stall_err;

endmodule
